ikaopll_pg_slotctrl: RTL

Slot sequencer and phase-reset scheduler for the phase generator. It runs the 18-slot time-division frame (9 channels × modulator/carrier) and tells the PG which slot it is processing. It converts per-channel key-on rising edges into per-slot phase reset requests. It also captures the channel 6 carrier phase word once per frame and shifts it out serially to the register block.

---
 rtl/ikaopll_pg_slotctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/ikaopll_pg_slotctrl.sv
// Slot sequencer for the PG: runs the 18-slot frame, turns key-on rising edges into
// per-slot phase reset requests, and serialises the channel 6 carrier phase word LSB first.
module ikaopll_pg_slotctrl #(
   parameter int NUM_CH   = 9,
   parameter int CAP_SLOT = 11
) (
   input  logic              i_EMUCLK,
   input  logic              i_MRST_n,
   input  logic              i_phi1_NCEN_n,
   input  logic              i_CYCLE_SYNC,
   input  logic [NUM_CH-1:0] i_KON,
   input  logic [9:0]        i_PHASEDATA,
   output logic [4:0]        o_SLOT,
   output logic [3:0]        o_CH,
   output logic              o_IS_CARRIER,
   output logic              o_PG_PHASE_RST,
   output logic              o_FRAME_START,
   output logic              o_CH6C2_SDATA,
   output logic              o_CH6C2_SVALID
);

   localparam logic [4:0] LAST_SLOT = 5'(2*NUM_CH - 1);
   localparam logic [4:0] CAP       = 5'(CAP_SLOT);

   logic [4:0]        r_slot;
   logic [NUM_CH-1:0] r_pending;
   logic [NUM_CH-1:0] r_kon_prev;
   logic              r_phase_rst;
   logic              r_frame_start;
   logic [9:0]        r_shift;
   logic [3:0]        r_bitcnt;
   logic              r_sdata;
   logic              r_svalid;

   logic              w_en;
   logic [4:0]        w_next;
   logic              w_fstart;
   logic [NUM_CH-1:0] w_rise;
   logic [NUM_CH-1:0] w_pend_upd;

   assign w_en     = ~i_phi1_NCEN_n;
   assign w_next   = (i_CYCLE_SYNC || (r_slot == LAST_SLOT)) ? 5'd0 : r_slot + 5'd1;
   assign w_fstart = (w_next == 5'd0);
   assign w_rise   = i_KON & ~r_kon_prev;

   // Carrier slot retires the channel's request; a fresh key-on at frame start overrides it.
   always_comb begin
      w_pend_upd = r_pending;
      if (r_slot[0]) begin
         w_pend_upd[r_slot[4:1]] = 1'b0;
      end
      if (w_fstart) begin
         w_pend_upd = w_pend_upd | w_rise;
      end
   end

   always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
      if (!i_MRST_n) begin
         r_slot        <= LAST_SLOT;
         r_pending     <= '0;
         r_kon_prev    <= '0;
         r_phase_rst   <= 1'b0;
         r_frame_start <= 1'b0;
      end else if (w_en) begin
         r_slot        <= w_next;
         r_pending     <= w_pend_upd;
         r_phase_rst   <= w_pend_upd[w_next[4:1]];
         r_frame_start <= w_fstart;
         if (w_fstart) begin
            r_kon_prev <= i_KON;
         end
      end
   end

   // Down-counter tracks the remaining valid bits; a capture always restarts it.
   always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
      if (!i_MRST_n) begin
         r_shift  <= '0;
         r_bitcnt <= '0;
         r_sdata  <= 1'b0;
         r_svalid <= 1'b0;
      end else if (w_en) begin
         if (r_slot == CAP) begin
            r_shift  <= i_PHASEDATA;
            r_bitcnt <= 4'd10;
            r_sdata  <= i_PHASEDATA[0];
            r_svalid <= 1'b1;
         end else if (r_bitcnt > 4'd1) begin
            r_shift  <= r_shift >> 1;
            r_sdata  <= r_shift[1];
            r_bitcnt <= r_bitcnt - 4'd1;
         end else if (r_bitcnt == 4'd1) begin
            r_bitcnt <= 4'd0;
            r_sdata  <= 1'b0;
            r_svalid <= 1'b0;
         end
      end
   end

   assign o_SLOT         = r_slot;
   assign o_CH           = r_slot[4:1];
   assign o_IS_CARRIER   = r_slot[0];
   assign o_PG_PHASE_RST = r_phase_rst;
   assign o_FRAME_START  = r_frame_start;
   assign o_CH6C2_SDATA  = r_sdata;
   assign o_CH6C2_SVALID = r_svalid;

endmodule
